// File: rtl/mem_stim_pkg.sv
// mem_stim_pkg: shared command, opcode and FSM state types for the memory stimulus driver
package mem_stim_pkg;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LW = 6;
  typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_CHECK, OP_IDLE} op_e;
  typedef enum logic [2:0] {IDLE_ST, WR_ST, RD_ISSUE, RD_RESP, CHK_ST, CHK_RESP, WAIT_ST} state_e;
  typedef struct packed {
    op_e           op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [LW-1:0] len;
  } cmd_t;
endpackage

// File: rtl/mem_stim_fifo.sv
// mem_stim_fifo: synchronous command FIFO with full/empty flags
module mem_stim_fifo import mem_stim_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output cmd_t dout,
  output logic full,
  output logic empty
);
  localparam int PW = $clog2(DEPTH);
  cmd_t mem [DEPTH];
  logic [PW:0] wp, rp;
  assign empty = wp == rp;
  assign full = wp == {~rp[PW], rp[PW-1:0]};
  assign dout = mem[rp[PW-1:0]];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) begin
        mem[wp[PW-1:0]] <= din;
        wp <= wp + 1'b1;
      end
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/mem_stim_driver.sv
// mem_stim_driver: host-command driven memory port stimulus (write/read/check/idle bursts)
module mem_stim_driver import mem_stim_pkg::*; #(
  parameter int DWIDTH     = DW,
  parameter int AWIDTH     = AW,
  parameter int BLENBIT    = LW,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [AWIDTH-1:0]  cmd_addr,
  input  logic [DWIDTH-1:0]  cmd_data,
  input  logic [BLENBIT-1:0] cmd_len,
  output logic               mem_ce,
  output logic               mem_we,
  output logic [AWIDTH-1:0]  mem_addr,
  output logic [DWIDTH-1:0]  mem_wdata,
  input  logic [DWIDTH-1:0]  mem_rdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DWIDTH-1:0]  rsp_data,
  output logic               rsp_err,
  output logic               cmd_done
);
  state_e state, state_n;
  cmd_t cmd_in, head;
  logic full, empty, pop, last, hs, chk_pend;
  logic [AWIDTH-1:0] base_addr, cur_addr, last_addr;
  logic [DWIDTH-1:0] base_data, pattern, last_wdata, prev_pat, cnt, cnt_n;
  logic [BLENBIT-1:0] len, beat;
  assign cmd_in = '{op: op_e'(cmd_op), addr: cmd_addr, data: cmd_data, len: cmd_len};
  assign cmd_ready = !full;
  assign last = beat == len;
  assign hs = rsp_valid && rsp_ready;
  assign cur_addr = base_addr + AWIDTH'(beat);
  assign pattern = base_data + DWIDTH'(beat);
  assign cnt_n = (chk_pend && mem_rdata != prev_pat && cnt != '1) ? cnt + 1'b1 : cnt;
  mem_stim_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(cmd_valid && !full),
    .din(cmd_in),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    state <= !rst_n ? IDLE_ST : state_n;
  end
  always_comb begin
    state_n = state;
    pop = 1'b0;
    case (state)
      IDLE_ST: if (!empty) begin
        pop = 1'b1;
        state_n = head.op == OP_WRITE ? WR_ST : head.op == OP_READ ? RD_ISSUE : head.op == OP_CHECK ? CHK_ST : WAIT_ST;
      end
      WR_ST, WAIT_ST: state_n = last ? IDLE_ST : state;
      RD_ISSUE: state_n = RD_RESP;
      RD_RESP: state_n = hs ? (last ? IDLE_ST : RD_ISSUE) : state;
      CHK_ST: state_n = last ? CHK_RESP : state;
      CHK_RESP: state_n = hs ? IDLE_ST : state;
      default: state_n = IDLE_ST;
    endcase
  end
  always_comb begin
    mem_ce = state inside {WR_ST, RD_ISSUE, CHK_ST};
    mem_we = state == WR_ST;
    mem_addr = mem_ce ? cur_addr : last_addr;
    mem_wdata = mem_ce ? pattern : last_wdata;
    cmd_done = (last && (state == WR_ST || state == WAIT_ST)) || (hs && ((state == RD_RESP && last) || state == CHK_RESP));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_addr <= '0;
      base_data <= '0;
      len <= '0;
      beat <= '0;
      last_addr <= '0;
      last_wdata <= '0;
      chk_pend <= 1'b0;
      prev_pat <= '0;
      cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (pop) begin
        base_addr <= head.addr;
        base_data <= head.data;
        len <= head.len;
        beat <= '0;
      end else if (!last && (state inside {WR_ST, CHK_ST, WAIT_ST} || (state == RD_RESP && hs))) begin
        beat <= beat + 1'b1;
      end
      if (mem_ce) begin
        last_addr <= mem_addr;
        last_wdata <= mem_wdata;
      end
      chk_pend <= state == CHK_ST;
      prev_pat <= pattern;
      cnt <= pop ? '0 : cnt_n;
      if ((state == RD_RESP || state == CHK_RESP) && !rsp_valid) begin
        rsp_valid <= 1'b1;
        rsp_data <= state == RD_RESP ? mem_rdata : cnt_n;
        rsp_err <= state == CHK_RESP && cnt_n != '0;
      end else if (hs) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_stim_driver.sv
// tb_mem_stim_driver: scoreboard bench for mem_stim_driver against a command-level memory model
module tb_mem_stim_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [5:0] cmd_len = '0;
  logic mem_ce, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic rsp_err;
  logic cmd_done;

  always #5 clk = ~clk;

  mem_stim_driver dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .cmd_done(cmd_done)
  );

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [31:0] d; logic e; } rsp_t;
  bit [31:0] ram [bit [31:0]];
  bit [31:0] ref_mem [bit [31:0]];
  wr_t exp_wr [$];
  rsp_t exp_rsp [$];
  wr_t w_got;
  rsp_t r_got;
  int wr_cyc [$];
  int n_cmp = 0, n_fail = 0, done_exp = 0, done_seen = 0, cyc = 0, ce_cnt = 0, rdy_mode = 2;
  bit sb_on = 1'b1;
  logic [31:0] last_rsp_d = '0;
  logic last_rsp_e = 1'b0;
  logic hold_p = 1'b0, hold_e = 1'b0;
  logic [31:0] hold_d = '0;
  logic p_ce = 1'b0, p_we = 1'b0;
  logic [31:0] p_a = '0, p_d = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm, input logic [31:0] act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got %h expected nothing", nm, act);
  endtask

  function automatic bit [31:0] ram_rd(input bit [31:0] a);
    return ram.exists(a) ? ram[a] : 32'h0;
  endfunction

  function automatic bit [31:0] ref_rd(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // memory array behind the port: writes land at the edge, reads return one cycle later
  always @(negedge clk) begin
    p_ce = mem_ce;
    p_we = mem_we;
    p_a = mem_addr;
    p_d = mem_wdata;
  end
  always @(posedge clk) begin
    if (p_ce) begin
      if (p_we) ram[p_a] = p_d;
      else mem_rdata <= ram_rd(p_a);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    rsp_ready = rdy_mode == 1 ? 1'($urandom_range(0, 1)) : rdy_mode == 2;
  end

  // monitor: pops expectations whenever the DUT writes or completes a response handshake
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (hold_p) begin
        chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_hold_data", rsp_data, hold_d);
        chk("rsp_hold_err", 32'(rsp_err), 32'(hold_e));
      end
      if (mem_ce && mem_we && sb_on) begin
        if (exp_wr.size() == 0) bad("unexpected_write", mem_addr);
        else begin
          w_got = exp_wr.pop_front();
          chk("wr_addr", mem_addr, w_got.a);
          chk("wr_data", mem_wdata, w_got.d);
          wr_cyc.push_back(cyc);
        end
      end
      if (rsp_valid && rsp_ready && sb_on) begin
        last_rsp_d = rsp_data;
        last_rsp_e = rsp_err;
        if (exp_rsp.size() == 0) bad("unexpected_rsp", rsp_data);
        else begin
          r_got = exp_rsp.pop_front();
          chk("rsp_data", rsp_data, r_got.d);
          chk("rsp_err", 32'(rsp_err), 32'(r_got.e));
        end
      end
      if (cmd_done) done_seen++;
      if (mem_ce) ce_cnt++;
    end
    hold_p = rst_n && rsp_valid && !rsp_ready;
    hold_d = rsp_data;
    hold_e = rsp_err;
  end

  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d, input logic [5:0] l);
    int mm = 0;
    logic [31:0] ak, dk;
    for (int k = 0; k <= int'(l); k++) begin
      ak = a + 32'(k);
      dk = d + 32'(k);
      case (op)
        2'd0: begin ref_mem[ak] = dk; exp_wr.push_back('{ak, dk}); end
        2'd1: exp_rsp.push_back('{ref_rd(ak), 1'b0});
        2'd2: if (ref_rd(ak) != dk) mm++;
        default: ;
      endcase
    end
    if (op == 2'd2) exp_rsp.push_back('{32'(mm), mm != 0});
    done_exp++;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d, input logic [5:0] l, input bit mdl);
    int n = 0;
    @(posedge clk);
    #1;
    cmd_op = op;
    cmd_addr = a;
    cmd_data = d;
    cmd_len = l;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (!cmd_ready) bad("cmd_accept_timeout", 32'(n));
    else if (mdl) model(op, a, d, l);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_wr.size() != 0 || exp_rsp.size() != 0 || done_seen != done_exp) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_wr_left", 32'(exp_wr.size()), 32'd0);
    chk("drain_rsp_left", 32'(exp_rsp.size()), 32'd0);
    chk("drain_done_count", 32'(done_seen), 32'(done_exp));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n, d0;
    logic [1:0] op;
    logic [5:0] l;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce", 32'(mem_ce), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_cmd_done", 32'(cmd_done), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;

    wr_cyc.delete();
    send(2'd0, 32'h0f0, 32'hA5A50000, 6'd3, 1'b1);
    drain();
    chk("wr_burst_beats", 32'(wr_cyc.size()), 32'd4);
    if (wr_cyc.size() == 4) chk("wr_burst_consecutive", 32'(wr_cyc[3] - wr_cyc[0]), 32'd3);

    rdy_mode = 0;
    send(2'd1, 32'h0f0, 32'h0, 6'd1, 1'b1);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      @(negedge clk);
      chk("rd_held_valid", 32'(rsp_valid), 32'd1);
      chk("rd_held_data", rsp_data, 32'hA5A50000);
    end
    rdy_mode = 2;
    drain();
    chk("rd_second_beat", last_rsp_d, 32'hA5A50001);

    ram[32'h0f2] = 32'h0BAD0000;
    ref_mem[32'h0f2] = 32'h0BAD0000;
    send(2'd2, 32'h0f0, 32'hA5A50000, 6'd3, 1'b1);
    drain();
    chk("chk_corrupt_count", last_rsp_d, 32'd1);
    chk("chk_corrupt_err", 32'(last_rsp_e), 32'd1);
    send(2'd2, 32'h0f0, 32'hA5A50000, 6'd1, 1'b1);
    drain();
    chk("chk_clean_count", last_rsp_d, 32'd0);
    chk("chk_clean_err", 32'(last_rsp_e), 32'd0);

    send(2'd0, 32'hFFFFFFFE, 32'h11110000, 6'd2, 1'b1);
    drain();
    chk("wrap_top", ram_rd(32'hFFFFFFFF), 32'h11110001);
    chk("wrap_zero", ram_rd(32'h0), 32'h11110002);

    send(2'd0, 32'h400, 32'h50000000, 6'd63, 1'b1);
    send(2'd2, 32'h400, 32'h50000000, 6'd63, 1'b1);
    drain();
    chk("maxlen_last", ram_rd(32'h43f), 32'h5000003f);
    chk("maxlen_beyond", ram_rd(32'h440), 32'h0);
    chk("maxlen_check", last_rsp_d, 32'd0);

    send(2'd3, 32'h0, 32'h0, 6'd40, 1'b1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) send(2'd0, 32'h500 + 32'(i * 8), 32'h600000 + 32'(i * 256), 6'd1, 1'b1);
    @(negedge clk);
    chk("fifo_full_ready", 32'(cmd_ready), 32'd0);
    send(2'd0, 32'h540, 32'h77, 6'd0, 1'b1);
    drain();

    sb_on = 1'b0;
    send(2'd0, 32'h200, 32'hC0000000, 6'd15, 1'b0);
    send(2'd0, 32'h280, 32'h1, 6'd0, 1'b0);
    n = 0;
    while (!(mem_ce && mem_we && mem_addr == 32'h205) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) bad("rst_beat5_timeout", 32'(n));
    rst_n = 1'b0;
    d0 = done_seen;
    @(posedge clk);
    #1;
    chk("midrst_ce", 32'(mem_ce), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_done", 32'(cmd_done), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ce_cnt = 0;
    repeat (20) @(negedge clk);
    chk("midrst_no_activity", 32'(ce_cnt), 32'd0);
    chk("midrst_no_done", 32'(done_seen), 32'(d0));
    for (int k = 0; k < 6; k++) begin
      chk("midrst_kept", ram_rd(32'h200 + 32'(k)), 32'hC0000000 + 32'(k));
      ref_mem[32'h200 + 32'(k)] = 32'hC0000000 + 32'(k);
    end
    chk("midrst_beat6", ram_rd(32'h206), 32'h0);
    chk("midrst_fifo_flushed", ram_rd(32'h280), 32'h0);
    sb_on = 1'b1;
    send(2'd2, 32'h200, 32'hC0000000, 6'd5, 1'b1);
    drain();
    chk("midrst_recheck", last_rsp_d, 32'd0);

    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      l = $urandom_range(0, 9) == 0 ? 6'd63 : 6'($urandom_range(0, 7));
      send(op, 32'h300 + 32'($urandom_range(0, 63)), $urandom, l, 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 10)) @(negedge clk);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
